// File: rtl/generic_input_debounce.sv
// Multi-channel input debouncer: two-flop synchronizer, shared sample prescaler,
// per-channel stability counters, edge pulses and sticky pending flags.
module generic_input_debounce #(
    parameter int unsigned IW = 1,
    parameter logic        DS = 1'b0,
    parameter int unsigned PW = 16,
    parameter int unsigned PD = 50000,
    parameter int unsigned CW = 4,
    parameter int unsigned DC = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [IW-1:0] i,
    output logic [IW-1:0] o,
    output logic [IW-1:0] rise,
    output logic [IW-1:0] fall,
    output logic          evt,
    output logic [IW-1:0] pend,
    input  logic [IW-1:0] clr
);

    localparam logic [PW-1:0] PD_LAST = PW'(PD - 1);
    localparam logic [CW-1:0] DC_LAST = CW'(DC - 1);

    logic [IW-1:0]         s1_q, s2_q;
    logic [PW-1:0]         pcnt_q, pcnt_d;
    logic                  tick;
    logic [IW-1:0][CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0]         o_q, o_d;
    logic [IW-1:0]         rise_q, rise_d;
    logic [IW-1:0]         fall_q, fall_d;
    logic                  evt_q, evt_d;
    logic [IW-1:0]         pend_q, pend_d;

    always_comb begin
        tick   = (pcnt_q == PD_LAST);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        cnt_d  = cnt_q;
        o_d    = o_q;
        rise_d = '0;
        fall_d = '0;
        for (int n = 0; n < IW; n++) begin
            if (tick) begin
                if (s2_q[n] == o_q[n]) begin
                    cnt_d[n] = '0;
                end else if (cnt_q[n] == DC_LAST) begin
                    cnt_d[n]  = '0;
                    o_d[n]    = s2_q[n];
                    rise_d[n] = s2_q[n];
                    fall_d[n] = ~s2_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + 1'b1;
                end
            end
        end
        evt_d  = |(rise_d | fall_d);
        // Registered pulses set pend, so a set always wins over a same-cycle clear.
        pend_d = (pend_q & ~clr) | rise_q | fall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= {IW{DS}};
            s2_q   <= {IW{DS}};
            pcnt_q <= '0;
            cnt_q  <= '0;
            o_q    <= {IW{DS}};
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= 1'b0;
            pend_q <= '0;
        end else begin
            s1_q   <= i;
            s2_q   <= s1_q;
            pcnt_q <= pcnt_d;
            cnt_q  <= cnt_d;
            o_q    <= o_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
            pend_q <= pend_d;
        end
    end

    assign o    = o_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign evt  = evt_q;
    assign pend = pend_q;

endmodule

// File: tb/tb_generic_input_debounce.sv
// Directed bench: one instance with PD=1/DC=4 for latency, glitch, pend and reset
// cases, a second with PD=5/DC=3 for prescaled behaviour.
module tb_generic_input_debounce;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ia, clra, oa, risea, falla, penda;
    logic       evta;
    logic [1:0] ib, clrb, ob, riseb, fallb, pendb;
    logic       evtb;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses;
    int nevt;
    int n;

    always #5 clk = ~clk;

    generic_input_debounce #(.IW(2), .DS(1'b0), .PW(16), .PD(1), .CW(4), .DC(4)) dut (
        .clk(clk), .rst_n(rst_n), .i(ia), .o(oa), .rise(risea), .fall(falla),
        .evt(evta), .pend(penda), .clr(clra)
    );

    generic_input_debounce #(.IW(2), .DS(1'b0), .PW(16), .PD(5), .CW(4), .DC(3)) dut_p (
        .clk(clk), .rst_n(rst_n), .i(ib), .o(ob), .rise(riseb), .fall(fallb),
        .evt(evtb), .pend(pendb), .clr(clrb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia = '0; clra = '0; ib = '0; clrb = '0;
        rst_n = 1'b0;
        repeat (3) step();
        check("rst_o", 32'(oa), 0);
        check("rst_pulses", 32'({risea, falla, evta}), 0);
        rst_n = 1'b1;
        step();
        check("post_rst_o", 32'(oa), 0);
        check("post_rst_pend", 32'(penda), 0);

        pulses = 0;
        repeat (20) begin
            step();
            if ((risea | falla) != 2'b00 || evta) pulses++;
        end
        check("idle_pulses", pulses, 0);

        // clean rising edge, then falling edge
        ia[0] = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 5) check("rise_o_early", 32'(oa), 0);
            if (e == 6) begin
                check("rise_o", 32'(oa), 1);
                check("rise_pulse", 32'(risea), 1);
                check("rise_evt", 32'(evta), 1);
                check("rise_pend_lag", 32'(penda), 0);
            end
            if (e == 7) begin
                check("rise_pulse_end", 32'(risea), 0);
                check("rise_pend", 32'(penda), 1);
            end
        end
        clra = 2'b01; step(); clra = '0;
        check("pend_clr", 32'(penda), 0);
        ia[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            if (e == 6) begin
                check("fall_pulse", 32'(falla), 1);
                check("fall_o", 32'(oa), 0);
            end
            if (e == 7) begin
                check("fall_pulse_end", 32'(falla), 0);
                check("fall_pend", 32'(penda), 1);
            end
        end
        clra = 2'b11; step(); clra = '0;

        // glitch: 3 high, 1 low, then steady high
        pulses = 0;
        ia[0] = 1'b1;
        repeat (3) begin step(); if (risea[0] || oa[0]) pulses++; end
        ia[0] = 1'b0;
        step(); if (risea[0] || oa[0]) pulses++;
        ia[0] = 1'b1;
        repeat (5) begin step(); if (risea[0] || oa[0]) pulses++; end
        check("glitch_no_pulse", pulses, 0);
        step();
        check("glitch_o", 32'(oa), 1);
        check("glitch_rise", 32'(risea), 1);
        ia[0] = 1'b0;
        repeat (8) step();
        clra = 2'b11; step(); clra = '0;
        check("glitch_settle", 32'({oa, penda}), 0);

        // prescaled instance: step latency and short-pulse rejection
        ib[1] = 1'b1;
        n = 0;
        while (ob[1] !== 1'b1 && n < 40) begin step(); n++; end
        check("pre_latency_in_range", 32'(n >= 13 && n <= 17), 1);
        repeat (3) step();
        ib[1] = 1'b0;
        repeat (9) step();
        ib[1] = 1'b1;
        pulses = 0;
        repeat (40) begin step(); if (ob[1] !== 1'b1 || fallb[1]) pulses++; end
        check("pre_short_reject", pulses, 0);

        // simultaneous change on both bits
        ia = 2'b11;
        nevt = 0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (evta) nevt++;
            if (e == 6) begin
                check("simul_rise", 32'(risea), 3);
                check("simul_evt", 32'(evta), 1);
            end
            if (e == 7) check("simul_pend", 32'(penda), 3);
        end
        check("simul_evt_count", nevt, 1);

        // clr coincident with a new set keeps pend set
        ia[0] = 1'b0;
        for (int e = 1; e <= 6; e++) step();
        check("fall0_pulse", 32'(falla), 1);
        clra = 2'b01; step(); clra = '0;
        check("pend_set_wins", 32'(penda), 3);
        clra = 2'b10; step(); clra = '0;
        check("pend_clr_bit1", 32'(penda), 1);

        // reset after 2 of 4 mismatch ticks
        ia = 2'b11;
        repeat (4) step();
        check("pre_rst_o", 32'(oa), 2);
        rst_n = 1'b0;
        #1;
        check("midrst_o", 32'(oa), 0);
        check("midrst_pend", 32'(penda), 0);
        step(); step();
        rst_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) check("restart_o_early", 32'(oa), 0);
            if (e == 6) begin
                check("restart_o", 32'(oa), 3);
                check("restart_rise", 32'(risea), 3);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
